ddr_read_engine: RTL and testbench

DDR read engine sitting directly downstream of the DDR client multiplexer: it accepts one read job (start address, beat count, configure pulse), splits it into memory read bursts, and buffers the returned beats in an internal FIFO. The multiplexer's selected client pops that FIFO. Burst issue is credit-gated, so the FIFO can never overflow even though the memory data channel has no backpressure.

---
 rtl/ddr_read_engine.sv | 219 +++++++++++++++++++++
 tb/tb_ddr_read_engine.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_read_engine.sv
// DDR read engine: splits a read job into credit-gated, 4 KB-safe bursts and buffers returned beats in a FWFT FIFO.
// Optional statistics counters are built only when DDR_RD_STAT_EN is defined.
module ddr_read_engine #(
  parameter int SINGLE_LEN   = 20,
  parameter int DDR_DATA_LEN = 512,
  parameter int DDR_ADDR_LEN = 32,
  parameter int BURST_MAX    = 16,
  parameter int FIFO_DEPTH   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out,
  input  logic [SINGLE_LEN-1:0]   ddr_len,
  input  logic                    ddr_conf,
  output logic                    busy,
  output logic                    done,
  output logic                    ddr_fifo_empty,
  input  logic                    ddr_fifo_req,
  output logic [DDR_DATA_LEN-1:0] ddr_fifo_data,
  output logic                    rd_cmd_valid,
  input  logic                    rd_cmd_ready,
  output logic [DDR_ADDR_LEN-1:0] rd_cmd_addr,
  output logic [7:0]              rd_cmd_len,
  input  logic                    rd_data_valid,
  input  logic [DDR_DATA_LEN-1:0] rd_data,
  output logic [31:0]             stat_stall_cycles,
  output logic [31:0]             stat_beats
);

  localparam int BYTES_PER_BEAT = DDR_DATA_LEN / 8;
  localparam int BEAT_SHIFT     = $clog2(BYTES_PER_BEAT);
  localparam int PAGE_BEATS     = 4096 / BYTES_PER_BEAT;
  localparam int PAGE_W         = $clog2(PAGE_BEATS);
  localparam int PTR_W          = $clog2(FIFO_DEPTH);
  localparam int CNT_W          = PTR_W + 1;
  localparam int BL_W           = $clog2(BURST_MAX) + 1;

  localparam logic [DDR_ADDR_LEN-1:0] ADDR_MASK = ~DDR_ADDR_LEN'(BYTES_PER_BEAT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  // Largest legal burst from addr: bounded by remaining beats, BURST_MAX and the next 4 KB page.
  function automatic logic [BL_W-1:0] burst_of(input logic [DDR_ADDR_LEN-1:0] addr,
                                               input logic [SINGLE_LEN-1:0]   rem);
    logic [PAGE_W:0]       to_page;
    logic [SINGLE_LEN-1:0] b;
    to_page = (PAGE_W + 1)'(PAGE_BEATS) - {1'b0, addr[BEAT_SHIFT +: PAGE_W]};
    b = rem;
    if (b > SINGLE_LEN'(BURST_MAX)) b = SINGLE_LEN'(BURST_MAX);
    if (b > SINGLE_LEN'(to_page))   b = SINGLE_LEN'(to_page);
    return BL_W'(b);
  endfunction

  logic [1:0]              state_q, state_d;
  logic [DDR_ADDR_LEN-1:0] addr_q, addr_d;
  logic [SINGLE_LEN-1:0]   rem_q, rem_d;
  logic [CNT_W-1:0]        out_q, out_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        free_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    cmd_valid_q, cmd_valid_d;
  logic [DDR_ADDR_LEN-1:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]              cmd_len_q, cmd_len_d;

  logic                    push, pop, hs, conf_acc;
  logic [BL_W-1:0]         hs_burst, next_burst;

  logic [DDR_DATA_LEN-1:0] fifo_mem [FIFO_DEPTH];

  // Beats with nothing outstanding (e.g. stragglers after reset) are dropped.
  assign push     = rd_data_valid && (out_q != '0);
  assign pop      = ddr_fifo_req && (cnt_q != '0);
  assign hs       = cmd_valid_q && rd_cmd_ready;
  assign hs_burst = BL_W'(cmd_len_q) + BL_W'(1);
  assign conf_acc = (state_q == S_IDLE) && !busy_q && ddr_conf;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cmd_valid_d = cmd_valid_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_len_d   = cmd_len_q;

    out_d    = out_q + (hs ? CNT_W'(hs_burst) : CNT_W'(0)) - (push ? CNT_W'(1) : CNT_W'(0));
    cnt_d    = cnt_q + (push ? CNT_W'(1) : CNT_W'(0)) - (pop ? CNT_W'(1) : CNT_W'(0));
    wr_ptr_d = wr_ptr_q + (push ? PTR_W'(1) : PTR_W'(0));
    rd_ptr_d = rd_ptr_q + (pop ? PTR_W'(1) : PTR_W'(0));

    unique case (state_q)
      S_IDLE: begin
        if (busy_q) begin
          // Closing cycle of a zero-length job.
          busy_d = 1'b0;
        end else if (conf_acc) begin
          busy_d = 1'b1;
          if (ddr_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_ISSUE;
            addr_d  = ddr_st_addr_out & ADDR_MASK;
            rem_d   = ddr_len;
          end
        end
      end
      S_ISSUE: begin
        if (hs) begin
          addr_d = addr_q + (DDR_ADDR_LEN'(hs_burst) << BEAT_SHIFT);
          rem_d  = rem_q - SINGLE_LEN'(hs_burst);
          if (rem_d == '0) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (out_d == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Credit check uses post-edge occupancy, so a command can follow its predecessor back to back.
    free_d     = CNT_W'(FIFO_DEPTH) - cnt_d - out_d;
    next_burst = burst_of(addr_d, rem_d);
    if (state_d != S_ISSUE) begin
      cmd_valid_d = 1'b0;
    end else if (!cmd_valid_q || rd_cmd_ready) begin
      cmd_valid_d = (free_d >= CNT_W'(next_burst));
      if (cmd_valid_d) begin
        cmd_addr_d = addr_d;
        cmd_len_d  = 8'(next_burst - BL_W'(1));
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      out_q       <= '0;
      cnt_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_len_q   <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      out_q       <= out_d;
      cnt_q       <= cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_len_q   <= cmd_len_d;
    end
  end

  // NOTE: the storage array has no reset; the pointers and count define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= rd_data;
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign ddr_fifo_empty = (cnt_q == '0);
  assign ddr_fifo_data  = ddr_fifo_empty ? '0 : fifo_mem[rd_ptr_q];
  assign rd_cmd_valid   = cmd_valid_q;
  assign rd_cmd_addr    = cmd_addr_q;
  assign rd_cmd_len     = cmd_len_q;

`ifdef DDR_RD_STAT_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] beats_q, beats_d;

  always_comb begin
    stall_d = stall_q + 32'(cmd_valid_q && !rd_cmd_ready);
    beats_d = beats_q + 32'(push);
    if (conf_acc) begin
      stall_d = '0;
      beats_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
      beats_q <= '0;
    end else begin
      stall_q <= stall_d;
      beats_q <= beats_d;
    end
  end

  assign stat_stall_cycles = stall_q;
  assign stat_beats        = beats_q;
`else
  assign stat_stall_cycles = '0;
  assign stat_beats        = '0;
`endif

endmodule

// File: tb/tb_ddr_read_engine.sv
// Self-checking bench for ddr_read_engine: directed jobs plus random jobs against a queue-based memory/FIFO model.
module tb_ddr_read_engine;

  localparam int SINGLE_LEN   = 20;
  localparam int DDR_DATA_LEN = 512;
  localparam int DDR_ADDR_LEN = 32;
  localparam int BURST_MAX    = 16;
  localparam int FIFO_DEPTH   = 64;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
  } cmd_t;

  logic                    clk;
  logic                    rst;
  logic [DDR_ADDR_LEN-1:0] ddr_st_addr_out;
  logic [SINGLE_LEN-1:0]   ddr_len;
  logic                    ddr_conf;
  logic                    busy;
  logic                    done;
  logic                    ddr_fifo_empty;
  logic                    ddr_fifo_req;
  logic [DDR_DATA_LEN-1:0] ddr_fifo_data;
  logic                    rd_cmd_valid;
  logic                    rd_cmd_ready;
  logic [DDR_ADDR_LEN-1:0] rd_cmd_addr;
  logic [7:0]              rd_cmd_len;
  logic                    rd_data_valid;
  logic [DDR_DATA_LEN-1:0] rd_data;
  logic [31:0]             stat_stall_cycles;
  logic [31:0]             stat_beats;

  ddr_read_engine #(
    .SINGLE_LEN  (SINGLE_LEN),
    .DDR_DATA_LEN(DDR_DATA_LEN),
    .DDR_ADDR_LEN(DDR_ADDR_LEN),
    .BURST_MAX   (BURST_MAX),
    .FIFO_DEPTH  (FIFO_DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .ddr_st_addr_out  (ddr_st_addr_out),
    .ddr_len          (ddr_len),
    .ddr_conf         (ddr_conf),
    .busy             (busy),
    .done             (done),
    .ddr_fifo_empty   (ddr_fifo_empty),
    .ddr_fifo_req     (ddr_fifo_req),
    .ddr_fifo_data    (ddr_fifo_data),
    .rd_cmd_valid     (rd_cmd_valid),
    .rd_cmd_ready     (rd_cmd_ready),
    .rd_cmd_addr      (rd_cmd_addr),
    .rd_cmd_len       (rd_cmd_len),
    .rd_data_valid    (rd_data_valid),
    .rd_data          (rd_data),
    .stat_stall_cycles(stat_stall_cycles),
    .stat_beats       (stat_beats)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Shared state between the directed sequence and the memory/consumer model.
  logic [511:0] exp_q[$];
  cmd_t         exp_cmd[$];
  int           pend_t[$];
  int           last_t = 0;
  int           beats_sent = 0;
  int           last_beat_cyc = -10;
  int           stall_model = 0;
  int           stray_n = 0;
  int           pop_quota = 0;
  int           pop_pct = 0;
  int           rdy_pct = 100;
  bit           pop_en = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] rand_beat();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference burst split: min(remaining, BURST_MAX, beats left in the 4 KB page).
  task automatic build_cmds(input logic [31:0] a, input int len);
    logic [31:0] aa;
    int r, b, pb;
    cmd_t c;
    aa = a & ~32'h3F;
    r  = len;
    while (r > 0) begin
      b  = (r > BURST_MAX) ? BURST_MAX : r;
      pb = 64 - int'((aa >> 6) & 32'h3F);
      if (b > pb) b = pb;
      c.addr = aa;
      c.len  = 8'(b - 1);
      exp_cmd.push_back(c);
      aa = aa + 32'(b * 64);
      r  = r - b;
    end
  endtask

  // Memory and consumer model, active on the falling edge.
  initial begin
    cmd_t         c;
    logic [511:0] beat;
    bit           hold_v;
    logic [31:0]  hold_a;
    logic [7:0]   hold_l;
    bit           want;
    int           t;
    hold_v = 0;
    hold_a = '0;
    hold_l = '0;
    ddr_fifo_req  = 1'b0;
    rd_cmd_ready  = 1'b0;
    rd_data_valid = 1'b0;
    rd_data       = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        pend_t.delete();
        last_t = 0;
        hold_v = 0;
        ddr_fifo_req  = 1'b0;
        rd_cmd_ready  = 1'b0;
        rd_data_valid = 1'b0;
        rd_data       = '0;
      end else begin
        check("fifo_empty", ddr_fifo_empty, exp_q.size() == 0);
        if (exp_q.size() > 0) check("fifo_head", ddr_fifo_data, exp_q[0]);
        check("credit_bound", (pend_t.size() + exp_q.size()) <= FIFO_DEPTH, 1);

        want = pop_en ? ($urandom_range(0, 99) < pop_pct) : (pop_quota > 0);
        ddr_fifo_req = want;
        if (want && exp_q.size() > 0) begin
          void'(exp_q.pop_front());
          if (!pop_en) pop_quota--;
        end

        if (hold_v) begin
          check("cmd_hold_valid", rd_cmd_valid, 1);
          check("cmd_hold_addr", rd_cmd_addr, hold_a);
          check("cmd_hold_len", rd_cmd_len, hold_l);
        end
        rd_cmd_ready = ($urandom_range(0, 99) < rdy_pct);
        if (rd_cmd_valid) begin
          check("cmd_expected", exp_cmd.size() > 0, 1);
          if (!rd_cmd_ready) stall_model++;
          if (rd_cmd_ready) begin
            if (exp_cmd.size() > 0) begin
              c = exp_cmd.pop_front();
              check("cmd_addr", rd_cmd_addr, c.addr);
              check("cmd_len", rd_cmd_len, c.len);
            end
            for (int i = 0; i <= int'(rd_cmd_len); i++) begin
              t = (cyc + 2 > last_t + 1) ? cyc + 2 : last_t + 1;
              pend_t.push_back(t);
              last_t = t;
            end
          end
        end
        hold_v = rd_cmd_valid && !rd_cmd_ready;
        hold_a = rd_cmd_addr;
        hold_l = rd_cmd_len;

        if (stray_n > 0) begin
          rd_data_valid = 1'b1;
          rd_data       = rand_beat();
          stray_n--;
        end else if (pend_t.size() > 0 && pend_t[0] <= cyc) begin
          beat = rand_beat();
          rd_data_valid = 1'b1;
          rd_data       = beat;
          exp_q.push_back(beat);
          void'(pend_t.pop_front());
          beats_sent++;
          last_beat_cyc = cyc;
        end else begin
          rd_data_valid = 1'b0;
          rd_data       = '0;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_cmd_valid"}, rd_cmd_valid, 0);
    check({tag, "_cmd_addr"}, rd_cmd_addr, 0);
    check({tag, "_cmd_len"}, rd_cmd_len, 0);
    check({tag, "_empty"}, ddr_fifo_empty, 1);
    check({tag, "_data"}, ddr_fifo_data, 0);
    check({tag, "_stat_stall"}, stat_stall_cycles, 0);
    check({tag, "_stat_beats"}, stat_beats, 0);
  endtask

  task automatic start_job(input logic [31:0] a, input int len);
    @(negedge clk);
    ddr_st_addr_out = a;
    ddr_len         = SINGLE_LEN'(len);
    ddr_conf        = 1'b1;
    build_cmds(a, len);
    stall_model   = 0;
    beats_sent    = 0;
    last_beat_cyc = -10;
    @(negedge clk);
    ddr_conf = 1'b0;
    check("busy_rise", busy, 1);
  endtask

  task automatic finish_job(input int len, input int budget, input int dup_at);
    int n;
    n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
      if (dup_at >= 0) begin
        ddr_conf        = (n == dup_at);
        ddr_st_addr_out = 32'h0BAD_0040;
        ddr_len         = SINGLE_LEN'(7);
      end
    end
    ddr_conf = 1'b0;
    check("done_seen", done, 1);
    check("busy_at_done", busy, len == 0);
    check("cmds_all_issued", exp_cmd.size(), 0);
    check("beats_delivered", beats_sent, len);
    if (len != 0) check("done_after_last_beat", cyc, last_beat_cyc + 1);
`ifdef DDR_RD_STAT_EN
    check("stat_beats", stat_beats, len);
    check("stat_stall", stat_stall_cycles, stall_model);
`else
    check("stat_beats_tied", stat_beats, 0);
    check("stat_stall_tied", stat_stall_cycles, 0);
`endif
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic wait_drain();
    int n;
    pop_en  = 1;
    pop_pct = 100;
    n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("drained", exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] a;
    int len, n;
    rst = 1'b1;
    ddr_conf = 1'b0;
    ddr_len = '0;
    ddr_st_addr_out = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    // Page-aligned job with an always-ready memory.
    rdy_pct = 100; pop_en = 1; pop_pct = 50;
    start_job(32'h0000_1000, 40);
    finish_job(40, 2000, -1);
    wait_drain();

    // Job straddling a 4 KB boundary.
    pop_pct = 60;
    start_job(32'h0000_0FC0, 4);
    finish_job(4, 500, -1);
    wait_drain();

    // Zero-length job.
    start_job(32'h0000_5000, 0);
    finish_job(0, 5, -1);

    // FIFO fills with no consumer; exactly 16 pops reopen credit.
    pop_en = 0; rdy_pct = 70;
    start_job(32'h0000_2000, 100);
    repeat (300) @(negedge clk);
    check("bp_beats_requested", beats_sent + pend_t.size(), FIFO_DEPTH);
    check("bp_cmd_blocked", rd_cmd_valid, 0);
    check("bp_busy", busy, 1);
    check("bp_not_empty", ddr_fifo_empty, 0);
    pop_quota = 16;
    n = 0;
    while (pop_quota > 0 && n < 40) begin @(negedge clk); n++; end
    check("bp_pops_done", pop_quota, 0);
    n = 0;
    while (rd_cmd_valid !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("bp_resume", rd_cmd_valid, 1);
    pop_en = 1; pop_pct = 70;
    finish_job(100, 3000, -1);
    wait_drain();

    // Second conf mid-job is ignored; consumer requests constantly, including on empty.
    pop_en = 1; pop_pct = 100; rdy_pct = 80;
    start_job(32'h0000_7F80, 24);
    finish_job(24, 2000, 4);
    wait_drain();

    // Random jobs, some near page ends, with unaligned low address bits.
    for (int i = 0; i < 6; i++) begin
      a = $urandom & 32'h0FFF_FFFF;
      if (i % 2 == 1) a = (a & ~32'hFFF) | 32'hF00 | (a & 32'h3F);
      len = $urandom_range(1, 90);
      rdy_pct = $urandom_range(40, 100);
      pop_en = 1;
      pop_pct = $urandom_range(30, 100);
      start_job(a, len);
      finish_job(len, 4000, -1);
      wait_drain();
    end

    // Reset mid-burst, then stray beats with nothing outstanding.
    pop_en = 0; rdy_pct = 100;
    start_job(32'h0000_3000, 64);
    repeat (6) @(negedge clk);
    check("pre_rst_busy", busy, 1);
    rst = 1'b1;
    exp_q.delete();
    exp_cmd.delete();
    pend_t.delete();
    last_t = 0;
    #1;
    check_reset_outputs("rst_mid");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    stray_n = 3;
    repeat (8) @(negedge clk);
    check("stray_all_sent", stray_n, 0);
    check_reset_outputs("post_stray");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
